// File: rtl/fifo_stream_reader.sv
// Read-side stage behind the synchronous FIFO. It issues credit-limited reads, absorbs
// the RAM read latency through a tag shift register and presents words as a valid/ready stream.
module fifo_stream_reader #(
  parameter int WIDTH      = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 1,
  parameter int CNT_WIDTH  = $clog2(BUF_DEPTH + RD_LATENCY + 1)
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 fifo_empty,
  output logic                 fifo_ren,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [CNT_WIDTH-1:0] level
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SUM_W = CNT_WIDTH + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [SUM_W-1:0] DEPTH_S  = SUM_W'(BUF_DEPTH);

  logic [WIDTH-1:0]      mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  logic [CNT_WIDTH-1:0]  infl_q, infl_d;
  logic [RD_LATENCY-1:0] tag_q, tag_d;
  logic                  valid_q;
  logic                  pop_s;
  logic                  cap_s;
  logic                  ren_s;
  logic [SUM_W-1:0]      credit_used_s;

  // Pointer increment that wraps at BUF_DEPTH-1, so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign pop_s         = valid_q & m_ready;
  assign cap_s         = tag_q[RD_LATENCY-1];
  assign credit_used_s = SUM_W'(occ_q) + SUM_W'(infl_q) - SUM_W'(pop_s);
  assign ren_s         = !srst && !fifo_empty && (credit_used_s < DEPTH_S);

  assign fifo_ren = ren_s;
  assign m_valid  = valid_q;
  assign m_data   = mem_q[head_q];
  assign level    = occ_q + infl_q;

  // Next-state for occupancy, pointers, in-flight count and the issue tags.
  always_comb begin
    occ_d  = occ_q;
    infl_d = infl_q;
    head_d = head_q;
    tail_d = tail_q;
    tag_d  = {RD_LATENCY{1'b0}};

    case ({cap_s, pop_s})
      2'b10:   occ_d = occ_q + CNT_WIDTH'(1);
      2'b01:   occ_d = occ_q - CNT_WIDTH'(1);
      default: occ_d = occ_q;
    endcase

    case ({ren_s, cap_s})
      2'b10:   infl_d = infl_q + CNT_WIDTH'(1);
      2'b01:   infl_d = infl_q - CNT_WIDTH'(1);
      default: infl_d = infl_q;
    endcase

    if (pop_s) begin
      head_d = ptr_inc(head_q);
    end else begin
      head_d = head_q;
    end

    if (cap_s) begin
      tail_d = ptr_inc(tail_q);
    end else begin
      tail_d = tail_q;
    end

    tag_d[0] = ren_s;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Control state; srst drops every in-flight tag so late RAM data is never captured.
  always_ff @(posedge clk) begin
    if (srst) begin
      occ_q   <= {CNT_WIDTH{1'b0}};
      infl_q  <= {CNT_WIDTH{1'b0}};
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      tag_q   <= {RD_LATENCY{1'b0}};
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      infl_q  <= infl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      tag_q   <= tag_d;
      valid_q <= (occ_d != {CNT_WIDTH{1'b0}});
    end
  end

  // Prefetch storage, written only on a tagged capture.
  always_ff @(posedge clk) begin
    if (!srst && cap_s) begin
      mem_q[tail_q] <= fifo_data;
    end
  end

  fifo_stream_reader_chk #(
    .CNT_WIDTH (CNT_WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_chk (
    .clk        (clk),
    .srst       (srst),
    .fifo_empty (fifo_empty),
    .fifo_ren   (ren_s),
    .capture    (cap_s),
    .occ        (occ_q),
    .level      (level)
  );

endmodule

// Protocol checker for the reader: credit discipline and FIFO read legality.
module fifo_stream_reader_chk #(
  parameter int CNT_WIDTH = 2,
  parameter int BUF_DEPTH = 2
) (
  input logic                 clk,
  input logic                 srst,
  input logic                 fifo_empty,
  input logic                 fifo_ren,
  input logic                 capture,
  input logic [CNT_WIDTH-1:0] occ,
  input logic [CNT_WIDTH-1:0] level
);

  a_no_ren_when_empty: assert property (@(posedge clk) disable iff (srst)
    !(fifo_ren && fifo_empty));

  a_no_capture_when_full: assert property (@(posedge clk) disable iff (srst)
    !(capture && (occ == CNT_WIDTH'(BUF_DEPTH))));

  a_level_bounded: assert property (@(posedge clk) disable iff (srst)
    (level <= CNT_WIDTH'(BUF_DEPTH)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: two reader instances (latency 1 / depth 2 and latency 3 / depth 4),
// each fed by a behavioural FIFO with matching read latency.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst = 1'b1;

  logic       empty1, ren1, mv1;
  logic       mr1 = 1'b0;
  logic [7:0] fd1, md1;
  logic [1:0] lvl1;

  logic       empty3, ren3, mv3;
  logic       mr3 = 1'b0;
  logic [7:0] fd3, md3;
  logic [2:0] lvl3;

  fifo_stream_reader #(.WIDTH(8), .RD_LATENCY(1), .BUF_DEPTH(2), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .srst(srst), .fifo_empty(empty1), .fifo_ren(ren1), .fifo_data(fd1),
    .m_valid(mv1), .m_ready(mr1), .m_data(md1), .level(lvl1));

  fifo_stream_reader #(.WIDTH(8), .RD_LATENCY(3), .BUF_DEPTH(4), .CNT_WIDTH(3)) dut3 (
    .clk(clk), .srst(srst), .fifo_empty(empty3), .fifo_ren(ren3), .fifo_data(fd3),
    .m_valid(mv3), .m_ready(mr3), .m_data(md3), .level(lvl3));

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural FIFOs: data appears RD_LATENCY cycles after a read, junk otherwise.
  logic [7:0] mem1 [64];
  logic [7:0] mem3 [64];
  logic [7:0] p3 [3];
  int wr1 = 0, rd1 = 0, wr3 = 0, rd3 = 0;
  logic [7:0] exp_q1 [$];
  logic [7:0] exp_q3 [$];

  assign empty1 = (rd1 >= wr1);
  assign empty3 = (rd3 >= wr3);
  assign fd3    = p3[2];

  always @(posedge clk) begin
    if (srst) rd1 <= 0; else if (ren1) rd1 <= rd1 + 1;
    if (srst) rd3 <= 0; else if (ren3) rd3 <= rd3 + 1;
    fd1   <= ren1 ? mem1[rd1 % 64] : 8'hEE;
    p3[0] <= ren3 ? mem3[rd3 % 64] : 8'hEE;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  task automatic push1(input logic [7:0] v);
    mem1[wr1 % 64] = v; wr1++; exp_q1.push_back(v);
  endtask

  task automatic push3(input logic [7:0] v);
    mem3[wr3 % 64] = v; wr3++; exp_q3.push_back(v);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int first_ren1, first_val1, first_pop1, last_pop1, pops1, rens1;
  int first_ren3, first_val3, first_pop3, last_pop3, pops3, rens3;
  logic hold1 = 1'b0, hold3 = 1'b0;
  logic [7:0] prev_d1, prev_d3;

  task automatic clear_stats();
    first_ren1 = -1; first_val1 = -1; first_pop1 = -1; last_pop1 = -1; pops1 = 0; rens1 = 0;
    first_ren3 = -1; first_val3 = -1; first_pop3 = -1; last_pop3 = -1; pops3 = 0; rens3 = 0;
  endtask

  // Output monitor: scoreboard compare on every handshake, plus stream stability rules.
  always @(negedge clk) begin
    if (srst) begin
      hold1 = 1'b0;
      hold3 = 1'b0;
    end else begin
      if (ren1) begin
        rens1++;
        if (first_ren1 < 0) first_ren1 = cyc;
        check_eq("ren_while_empty1", empty1, 0);
      end
      if (mv1 && first_val1 < 0) first_val1 = cyc;
      if (hold1) begin
        check_eq("valid_held1", mv1, 1);
        check_eq("data_held1", md1, prev_d1);
      end
      if (mv1 && mr1) begin
        check_eq("sb_nonempty1", exp_q1.size() != 0, 1);
        if (exp_q1.size() != 0) check_eq("data1", md1, exp_q1.pop_front());
        pops1++;
        if (first_pop1 < 0) first_pop1 = cyc;
        last_pop1 = cyc;
      end
      check_eq("level_max1", lvl1 <= 2'd2, 1);
      hold1   = mv1 && !mr1;
      prev_d1 = md1;

      if (ren3) begin
        rens3++;
        if (first_ren3 < 0) first_ren3 = cyc;
        check_eq("ren_while_empty3", empty3, 0);
      end
      if (mv3 && first_val3 < 0) first_val3 = cyc;
      if (hold3) begin
        check_eq("valid_held3", mv3, 1);
        check_eq("data_held3", md3, prev_d3);
      end
      if (mv3 && mr3) begin
        check_eq("sb_nonempty3", exp_q3.size() != 0, 1);
        if (exp_q3.size() != 0) check_eq("data3", md3, exp_q3.pop_front());
        pops3++;
        if (first_pop3 < 0) first_pop3 = cyc;
        last_pop3 = cyc;
      end
      check_eq("level_max3", lvl3 <= 3'd4, 1);
      hold3   = mv3 && !mr3;
      prev_d3 = md3;
    end
  end

  // Called at posedge+#1: asserts srst and resets the FIFO models and scoreboards.
  task automatic start_reset();
    srst = 1'b1;
    mr1  = 1'b0;
    mr3  = 1'b0;
    wr1  = 0;
    wr3  = 0;
    exp_q1.delete();
    exp_q3.delete();
  endtask

  task automatic end_reset(input string tag);
    @(posedge clk); #1;
    check_eq({tag, "_rst_valid1"}, mv1, 0);
    check_eq({tag, "_rst_level1"}, lvl1, 0);
    check_eq({tag, "_rst_ren1"}, ren1, 0);
    check_eq({tag, "_rst_valid3"}, mv3, 0);
    check_eq({tag, "_rst_level3"}, lvl3, 0);
    check_eq({tag, "_rst_ren3"}, ren3, 0);
    clear_stats();
    srst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q1.size() != 0 || mv1 || exp_q3.size() != 0 || mv3) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_drain_in_time"}, n < budget, 1);
  endtask

  initial begin
    int n;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;

    // Streaming at full rate, latency 1
    start_reset();
    for (int i = 1; i <= 16; i++) push1(8'(i));
    mr1 = 1'b1;
    end_reset("t1");
    drain("t1", 100);
    check_eq("t1_first_latency", first_val1 - first_ren1, 2);
    check_eq("t1_pops", pops1, 16);
    check_eq("t1_back_to_back", last_pop1 - first_pop1, 15);
    check_eq("t1_level_end", lvl1, 0);

    // Backpressure: credits run out, then resume at full rate
    start_reset();
    for (int i = 1; i <= 16; i++) push1(8'(i));
    end_reset("t2");
    repeat (10) @(posedge clk);
    #1;
    check_eq("t2_reads_issued", rens1, 2);
    check_eq("t2_ren_stalled", ren1, 0);
    check_eq("t2_level_full", lvl1, 2);
    check_eq("t2_valid", mv1, 1);
    check_eq("t2_head_data", md1, 8'h01);
    mr1 = 1'b1;
    drain("t2", 100);
    check_eq("t2_pops", pops1, 16);
    check_eq("t2_back_to_back", last_pop1 - first_pop1, 15);
    check_eq("t2_reads_total", rens1, 16);

    // Random ready against an 8-word burst
    start_reset();
    for (int i = 0; i < 8; i++) push1(8'($urandom_range(0, 255)));
    end_reset("t3");
    n = 0;
    while ((exp_q1.size() != 0 || mv1) && n < 300) begin
      mr1 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check_eq("t3_in_time", n < 300, 1);
    check_eq("t3_pops", pops1, 8);
    check_eq("t3_reads", rens1, 8);

    // FIFO empties while one read is still in flight
    start_reset();
    push1(8'hA1); push1(8'hA2); push1(8'hA3);
    mr1 = 1'b1;
    end_reset("t4");
    n = 0;
    while (rens1 < 3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("t4_empty_now", empty1, 1);
    check_eq("t4_level_inflight", lvl1, 2);
    drain("t4", 50);
    repeat (5) @(posedge clk);
    #1;
    check_eq("t4_pops", pops1, 3);
    check_eq("t4_valid_low", mv1, 0);
    check_eq("t4_level_zero", lvl1, 0);

    // Reset with words buffered and reads in flight (latency 3)
    start_reset();
    for (int i = 0; i < 10; i++) push3(8'(8'h40 + i));
    end_reset("t5a");
    n = 0;
    while (!(first_ren3 >= 0 && cyc == first_ren3 + 5) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("t5_level_before", lvl3, 4);
    check_eq("t5_valid_before", mv3, 1);
    check_eq("t5_head_before", md3, 8'h40);
    start_reset();
    end_reset("t5b");
    repeat (6) begin
      @(posedge clk); #1;
      check_eq("t5_idle_valid", mv3, 0);
      check_eq("t5_idle_level", lvl3, 0);
    end
    for (int i = 0; i < 5; i++) push3(8'(8'hB0 + i));
    mr3 = 1'b1;
    drain("t5", 60);
    check_eq("t5_pops_after", pops3, 5);

    // 32-word burst at full rate, latency 3, depth 4
    start_reset();
    for (int i = 0; i < 32; i++) push3(8'(i * 7 + 3));
    mr3 = 1'b1;
    end_reset("t6");
    drain("t6", 200);
    check_eq("t6_first_latency", first_val3 - first_ren3, 4);
    check_eq("t6_pops", pops3, 32);
    check_eq("t6_back_to_back", last_pop3 - first_pop3, 31);
    check_eq("t6_level_end", lvl3, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side stage that sits directly downstream of the synchronous FIFO.
- Drives the FIFO's read enable and absorbs the fixed read latency of the FIFO RAM.
- Presents the popped words as a valid/ready stream with full one-word-per-cycle throughput.
- Backpressure from the consumer is fully decoupled from the FIFO read timing by an internal prefetch buffer.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- RD_LATENCY, 1, cycles from an accepted fifo_ren to valid fifo_data; legal range 1..4.
- BUF_DEPTH, RD_LATENCY+1, prefetch buffer entries; minimum RD_LATENCY+1 for full throughput.
- CNT_WIDTH, $clog2(BUF_DEPTH+RD_LATENCY+1), width of the level output.

Ports:
- clk  input  1  clock; all logic rising-edge.
- srst  input  1  synchronous reset, active-high.
- fifo_empty  input  1  empty flag from the FIFO.
- fifo_ren  output  1  read enable to the FIFO.
- fifo_data  input  WIDTH  FIFO read data, valid RD_LATENCY cycles after an issued read.
- m_valid  output  1  output word available.
- m_ready  input  1  consumer accepts the word.
- m_data  output  WIDTH  output word; head of the prefetch buffer.
- level  output  CNT_WIDTH  words buffered plus reads in flight.

Behaviour:
- Interface: reset srst, synchronous, active-high; clock clk.
- Reset:
  - Clear buffer head, tail and occupancy, the in-flight count, and the issue shift register.
  - After reset: m_valid=0, level=0, fifo_ren=0.
  - fifo_ren is forced 0 in any cycle where srst=1.
  - m_data is don't-care while m_valid=0.
- Pop: pop = m_valid & m_ready. On pop, advance head (modulo BUF_DEPTH) and decrement occupancy.
- Issue (combinational):
  - fifo_ren = !srst & !fifo_empty & ((occ + inflight - pop) < BUF_DEPTH).
  - Issue is credit-based, so the buffer can never overflow.
- Issue tracking:
  - An RD_LATENCY-deep shift register records issued reads.
  - When its output bit is 1, write fifo_data at tail, advance tail, and increment occupancy.
  - inflight = popcount of the shift register, or an equivalent counter incremented on issue and decremented on capture.
  - Data is captured only by the shift-register tag. Never sample fifo_data otherwise.
- Simultaneous capture and pop in one cycle:
  - Occupancy is unchanged.
  - When occ=0 the captured word becomes visible the next cycle. There is no bypass: the first word appears exactly RD_LATENCY+1 cycles after the issue cycle.
- Output: m_valid = (occ != 0), registered state only. m_data = buf[head].
- Stream rules:
  - Once m_valid=1, m_data is held stable until pop.
  - m_valid is never withdrawn without a pop, except by srst.
- level = occ + inflight. Width rule: max value BUF_DEPTH+RD_LATENCY must fit in CNT_WIDTH.
- Throughput: with fifo_empty=0 and m_ready=1 continuously, one word is output per cycle in steady state.
- FIFO empty: no issue; words already in flight are still captured and delivered.
- m_ready low: issue stops once occ+inflight reaches BUF_DEPTH. Issue resumes in the same cycle as the pop that frees a credit.
- Reset mid-operation:
  - In-flight tags and buffered words are discarded.
  - fifo_data arriving after srst deasserts is ignored, because the shift register is cleared.
  - The FIFO is reset on the same srst.
- Word order: output order equals FIFO read order. No drops, no duplicates.
- Pointer wrap: head and tail wrap from BUF_DEPTH-1 to 0. Works for BUF_DEPTH that is not a power of two.
- Assertions for the verifier:
  - No capture when occ=BUF_DEPTH.
  - fifo_ren never asserted while fifo_empty=1.

Test Plan:
- Reset, then a FIFO preloaded with 0x01..0x10, m_ready=1 (RD_LATENCY=1) -> first m_valid on cycle 2 after the first fifo_ren; 16 consecutive beats 0x01..0x10, one per cycle; level returns to 0.
- Same preload, m_ready=0 -> exactly BUF_DEPTH reads issued; fifo_ren then stays 0; level=BUF_DEPTH; m_data=0x01 held stable. Raising m_ready resumes at full rate with no gaps or loss.
- m_ready toggled at random 50% against an 8-word FIFO burst -> output sequence identical to input, no duplicates; fifo_ren never asserted when fifo_empty=1.
- FIFO goes empty mid-stream while 1 read is in flight -> the in-flight word is still delivered; m_valid falls after the last pop; no spurious capture.
- srst asserted one cycle after a fifo_ren issue, with occ=2 -> next cycle m_valid=0, level=0; the late fifo_data is not captured; the next stream after reset starts cleanly.
- RD_LATENCY=3, BUF_DEPTH=4, continuous m_ready=1 with a 32-word burst -> 1 word per cycle after a 4-cycle initial latency; level never exceeds 4.
